laser_packet_tx: RTL and testbench

Parametrised successor to the laser-link serial transmitter. It serialises a PKT_LENGTH-bit packet as a stream of UART-style framed words, each with a start bit, WORD_BITS data bits and STOP_BITS stop bits, at CLK_PER_BIT clocks per bit. A one-deep pending buffer allows back-to-back packets, and the block adds abort and overrun reporting. It sits between the packet generator and the laser pin (JA[0]).

---
 rtl/laser_packet_tx.sv | 222 ++++++++++++++++++++++
 tb/tb_laser_packet_tx.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_packet_tx.sv
// Laser-link serial transmitter: sends a PKT_LENGTH-bit packet as UART-framed words, MSB word first, LSB bit first.
// Optional even-parity bit per word when the PARITY_EN macro is defined.
module laser_packet_tx #(
   parameter int CLK_PER_BIT = 54166,
   parameter int PKT_LENGTH  = 288,
   parameter int WORD_BITS   = 8,
   parameter int STOP_BITS   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [PKT_LENGTH-1:0] data,
   input  logic                  new_data,
   input  logic                  abort,
   output logic                  tx,
   output logic                  busy,
   output logic                  ready,
   output logic                  done,
   output logic                  overrun
);

   localparam int NUM_WORDS = PKT_LENGTH / WORD_BITS;
   localparam int CNT_W     = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam int BIT_W     = $clog2(WORD_BITS + 1);
   localparam int WIDX_W    = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
      S_START,
      S_DATA,
`ifdef PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   state_t                state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [BIT_W-1:0]      bit_q, bit_d;
   logic [WIDX_W-1:0]     widx_q, widx_d;
   logic [PKT_LENGTH-1:0] shift_q, shift_d;
   logic [WORD_BITS-1:0]  word_q, word_d;
   logic [PKT_LENGTH-1:0] pend_q, pend_d;
   logic                  pvld_q, pvld_d;
   logic                  tx_q, tx_d;
   logic                  busy_q, busy_d;
   logic                  ready_q, ready_d;
   logic                  done_q, done_d;
   logic                  ovr_q, ovr_d;
   logic                  bit_end;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         bit_q   <= '0;
         widx_q  <= '0;
         shift_q <= '0;
         word_q  <= '0;
         pend_q  <= '0;
         pvld_q  <= 1'b0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         ready_q <= 1'b1;
         done_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bit_q   <= bit_d;
         widx_q  <= widx_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         pend_q  <= pend_d;
         pvld_q  <= pvld_d;
         tx_q    <= tx_d;
         busy_q  <= busy_d;
         ready_q <= ready_d;
         done_q  <= done_d;
         ovr_q   <= ovr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bit_d   = bit_q;
      widx_d  = widx_q;
      shift_d = shift_q;
      word_d  = word_q;
      pend_d  = pend_q;
      pvld_d  = pvld_q;
      tx_d    = tx_q;
      busy_d  = busy_q;
      ready_d = ready_q;
      done_d  = 1'b0;
      ovr_d   = ovr_q;
      bit_end = (cnt_q == CNT_W'(CLK_PER_BIT - 1));

      // tx_d always carries the level of the bit that starts at the next edge
      unique case (state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (pvld_q) begin
               state_d = S_LOAD;
               busy_d  = 1'b1;
            end
         end
         S_LOAD: begin
            shift_d = pend_q;
            word_d  = pend_q[PKT_LENGTH-1 -: WORD_BITS];
            pvld_d  = 1'b0;
            ready_d = 1'b1;
            busy_d  = 1'b1;
            widx_d  = '0;
            cnt_d   = '0;
            bit_d   = '0;
            tx_d    = 1'b0;
            state_d = S_START;
         end
         S_START: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = word_q[0];
               state_d = S_DATA;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         S_DATA: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == BIT_W'(WORD_BITS - 1)) begin
                  bit_d   = '0;
`ifdef PARITY_EN
                  tx_d    = ^shift_q[PKT_LENGTH-1 -: WORD_BITS];
                  state_d = S_PARITY;
`else
                  tx_d    = 1'b1;
                  state_d = S_STOP;
`endif
               end else begin
                  bit_d  = bit_q + BIT_W'(1);
                  word_d = word_q >> 1;
                  tx_d   = word_d[0];
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`ifdef PARITY_EN
         S_PARITY: begin
            if (bit_end) begin
               cnt_d   = '0;
               bit_d   = '0;
               tx_d    = 1'b1;
               state_d = S_STOP;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
`endif
         S_STOP: begin
            if (bit_end) begin
               cnt_d = '0;
               if (bit_q == BIT_W'(STOP_BITS - 1)) begin
                  bit_d = '0;
                  if (widx_q != WIDX_W'(NUM_WORDS - 1)) begin
                     widx_d  = widx_q + WIDX_W'(1);
                     shift_d = shift_q << WORD_BITS;
                     word_d  = shift_d[PKT_LENGTH-1 -: WORD_BITS];
                     tx_d    = 1'b0;
                     state_d = S_START;
                  end else begin
                     done_d  = 1'b1;
                     busy_d  = 1'b0;
                     tx_d    = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  bit_d = bit_q + BIT_W'(1);
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase

      // LOAD frees the pending slot this cycle, so a request landing on LOAD is taken
      if (new_data) begin
         if (ready_q || state_q == S_LOAD) begin
            pend_d  = data;
            pvld_d  = 1'b1;
            ready_d = 1'b0;
         end else begin
            ovr_d = 1'b1;
         end
      end

      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         bit_d   = '0;
         widx_d  = '0;
         pvld_d  = 1'b0;
         tx_d    = 1'b1;
         busy_d  = 1'b0;
         ready_d = 1'b1;
         done_d  = 1'b0;
         ovr_d   = ovr_q;
      end
   end

   assign tx      = tx_q;
   assign busy    = busy_q;
   assign ready   = ready_q;
   assign done    = done_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_laser_packet_tx.sv
// Bench for laser_packet_tx: vector table, directed multi-cycle corners and a random run against a frame model.
module tb_laser_packet_tx;

   localparam int CPB  = 4;
   localparam int PKT  = 16;
   localparam int W    = 8;
   localparam int STB  = 1;
   localparam int NW   = PKT / W;
`ifdef PARITY_EN
   localparam int FB   = 2 + W + STB;
`else
   localparam int FB   = 1 + W + STB;
`endif
   localparam int TOT  = NW * FB;

   typedef struct {
      logic [15:0]    data;
      logic [TOT-1:0] frame;
   } vec_t;

   logic           clk = 1'b0;
   logic           rst;
   logic [PKT-1:0] data_in;
   logic           new_data;
   logic           abort;
   logic           tx, busy, ready, done, overrun;

   int checks   = 0;
   int failures = 0;

   laser_packet_tx #(.CLK_PER_BIT(CPB), .PKT_LENGTH(PKT), .WORD_BITS(W), .STOP_BITS(STB)) dut (
      .clk(clk), .rst(rst), .data(data_in), .new_data(new_data), .abort(abort),
      .tx(tx), .busy(busy), .ready(ready), .done(done), .overrun(overrun)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   // Expected serial stream for one packet, first transmitted bit in the MSB position
   function automatic logic [TOT-1:0] model_frame(input logic [15:0] d);
      bit q[$];
      logic [TOT-1:0] f;
      for (int w = 0; w < NW; w++) begin
         int unsigned wv = (int'(d) >> (PKT - W * (w + 1))) % (1 << W);
         bit par = 0;
         q.push_back(1'b0);
         for (int b = 0; b < W; b++) begin
            bit v = bit'((wv >> b) & 1);
            q.push_back(v);
            par ^= v;
         end
`ifdef PARITY_EN
         q.push_back(par);
`endif
         for (int s = 0; s < STB; s++) q.push_back(1'b1);
      end
      for (int i = 0; i < TOT; i++) f[TOT-1-i] = q[i];
      return f;
   endfunction

   task automatic issue(input logic [15:0] d);
      @(negedge clk);
      data_in  = d;
      new_data = 1'b1;
      @(negedge clk);
      new_data = 1'b0;
   endtask

   task automatic wait_frame(input logic [TOT-1:0] exp, input string nm, output int lat);
      int errs = 0;
      int pre_done = 0;
      logic busy_last = 1'b0;
      logic [TOT-1:0] got = '0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
         if (tx !== 1'b0) begin
            busy_last = busy;
            if (done === 1'b1) pre_done++;
         end
      end while (tx !== 1'b0 && lat < 200);
      if (tx !== 1'b0) begin
         check({nm, " start timeout"}, tx, 0);
         return;
      end
      check({nm, " busy_load"}, busy_last, 1);
      check({nm, " done_width"}, pre_done, 0);
      for (int c = 1; c < TOT * CPB; c++) begin
         @(negedge clk);
         if (tx !== exp[TOT-1-c/CPB]) errs++;
         if (busy !== 1'b1) errs++;
         if (done !== 1'b0) errs++;
         if (c % CPB == CPB / 2) got[TOT-1-c/CPB] = tx;
      end
      check({nm, " frame"}, got, exp);
      check({nm, " hold_errs"}, errs, 0);
      @(negedge clk);
      check({nm, " done_at_end"}, {done, busy, tx}, 3'b101);
   endtask

   vec_t tbl[$];
   int   lat, k, errs;
   logic [15:0] rd;

   initial begin
`ifdef PARITY_EN
      tbl.push_back('{16'hA507, 22'b01010010101_01110000011});
`else
      tbl.push_back('{16'hA53C, 20'b0101001011_0001111001});
      tbl.push_back('{16'h00FF, 20'b0000000001_0111111111});
      tbl.push_back('{16'h1234, 20'b0010010001_0001011001});
      tbl.push_back('{16'h5678, 20'b0011010101_0000111101});
`endif
      rst = 1'b1; data_in = '0; new_data = 1'b0; abort = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", {tx, busy, ready, done, overrun}, 5'b10100);
      rst = 1'b0;
      @(negedge clk);
      check("idle_after_reset", {tx, busy, ready, done, overrun}, 5'b10100);

      for (int i = 0; i < tbl.size(); i++) begin
         issue(tbl[i].data);
         wait_frame(tbl[i].frame, $sformatf("tbl%0d", i), lat);
         check($sformatf("tbl%0d latency", i), lat, 2);
      end

      for (int i = 0; i < 6; i++) begin
         rd = 16'($urandom_range(0, 65535));
         issue(rd);
         wait_frame(model_frame(rd), $sformatf("rand%0d_%h", i, rd), lat);
         check($sformatf("rand%0d latency", i), lat, 2);
      end

      // back-to-back: second packet queued while the first is on the wire
      issue(16'h1234);
      fork
         begin
            int l1, l2;
            wait_frame(model_frame(16'h1234), "b2b_a", l1);
            wait_frame(model_frame(16'h5678), "b2b_b", l2);
            check("b2b gap", l2, 2);
         end
         begin
            repeat (30) @(negedge clk);
            issue(16'h5678);
            check("b2b ready_low", ready, 0);
            k = 0;
            while (ready !== 1'b1 && k < 400) begin
               @(negedge clk);
               k++;
            end
            check("b2b ready_rise", k, TOT * CPB - 28);
         end
      join
      check("b2b overrun", overrun, 0);

      // overrun: third request with the pending buffer full is dropped
      issue(16'h1234);
      fork
         begin
            int l1, l2;
            wait_frame(model_frame(16'h1234), "ovr_a", l1);
            wait_frame(model_frame(16'h5678), "ovr_b", l2);
            check("ovr gap", l2, 2);
         end
         begin
            repeat (10) @(negedge clk);
            issue(16'h5678);
            check("ovr pre", overrun, 0);
            issue(16'hFFFF);
            check("ovr set", overrun, 1);
         end
      join
      check("ovr sticky", overrun, 1);

      // abort in data bit 3 of word 0
      issue(16'h1234);
      k = 0;
      do begin @(negedge clk); k++; end while (tx !== 1'b0 && k < 50);
      check("abort start", tx, 0);
      repeat (17) @(negedge clk);
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      check("abort next", {tx, busy, ready, done, overrun}, 5'b10101);
      errs = 0;
      repeat (40) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) errs++;
      end
      check("abort quiet", errs, 0);
      issue(16'h00FF);
      wait_frame(model_frame(16'h00FF), "post_abort", lat);
      check("post_abort latency", lat, 2);

      // abort and new_data together: abort wins
      @(negedge clk);
      data_in = 16'h1111; new_data = 1'b1; abort = 1'b1;
      @(negedge clk);
      new_data = 1'b0; abort = 1'b0;
      check("abort_vs_new ready", ready, 1);
      errs = 0;
      repeat (20) begin
         @(negedge clk);
         if (tx !== 1'b1 || busy !== 1'b0) errs++;
      end
      check("abort_vs_new quiet", errs, 0);

      // asynchronous reset in the middle of word 0 stop bit
      issue(16'h5678);
      k = 0;
      do begin @(negedge clk); k++; end while (tx !== 1'b0 && k < 50);
      repeat ((FB - 1) * CPB + 1) @(negedge clk);
      check("pre_rst state", {tx, busy, overrun}, 3'b111);
      #2 rst = 1'b1;
      #1 check("async_rst", {tx, busy, ready, done, overrun}, 5'b10100);
      @(negedge clk);
      rst = 1'b0;
      issue(16'hA53C);
      wait_frame(model_frame(16'hA53C), "post_rst", lat);
      check("post_rst latency", lat, 2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
